// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues divide/remainder requests to a non-restoring divider and returns tagged results.
// Optional result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
    parameter int args_width = 32,
    parameter int tag_width  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sgn,
    input  logic                  req_rem,
    input  logic [args_width-1:0] req_a,
    input  logic [args_width-1:0] req_b,
    input  logic [tag_width-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [args_width-1:0] resp_data,
    output logic [tag_width-1:0]  resp_tag,
    output logic                  resp_dz,
    output logic                  div_enable,
    output logic                  div_unsgn_or_sgn,
    output logic [args_width-1:0] div_num,
    output logic [args_width-1:0] div_denom,
    input  logic                  div_can_accept_cmd,
    input  logic                  div_data_ready,
    input  logic [args_width-1:0] div_quot,
    input  logic [args_width-1:0] div_rem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [args_width-1:0] MIN_NEG = {1'b1, {(args_width-1){1'b0}}};
    state_t                state, state_nx;
    logic                  live;
    logic [args_width-1:0] a_q, b_q, res_q;
    logic [tag_width-1:0]  tag_q;
    logic                  sgn_q, rem_q, dz_q, seen_busy;
    logic                  accept, b_zero, ovf, hit, done;
    logic [args_width-1:0] hit_data;
    assign accept = req_valid && req_ready;
    assign b_zero = req_b == '0;
    assign ovf    = req_sgn && req_a == MIN_NEG && req_b == '1;
    // busy must be seen first so a data_ready left from the previous command is ignored
    assign done   = seen_busy && div_can_accept_cmd && div_data_ready;
`ifdef DIV_RESULT_CACHE_EN
    logic                  c_valid, c_sgn;
    logic [args_width-1:0] c_a, c_b, c_quot, c_rem;
    assign hit      = c_valid && c_a == req_a && c_b == req_b && c_sgn == req_sgn;
    assign hit_data = req_rem ? c_rem : c_quot;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_quot  <= '0;
            c_rem   <= '0;
        end else if (state == WAIT && done) begin
            c_valid <= 1'b1;
            c_sgn   <= sgn_q;
            c_a     <= a_q;
            c_b     <= b_q;
            c_quot  <= div_quot;
            c_rem   <= div_rem;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (b_zero || ovf || hit) ? RESP : ISSUE;
            ISSUE: if (div_can_accept_cmd) state_nx = WAIT;
            WAIT:  if (done) state_nx = RESP;
            RESP:  if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = state == IDLE && live;
        resp_valid = state == RESP;
        div_enable = state == ISSUE && div_can_accept_cmd;
    end
    assign div_num          = a_q;
    assign div_denom        = b_q;
    assign div_unsgn_or_sgn = sgn_q;
    assign resp_data        = res_q;
    assign resp_tag         = tag_q;
    assign resp_dz          = dz_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            rem_q     <= 1'b0;
            tag_q     <= '0;
            dz_q      <= 1'b0;
            res_q     <= '0;
            seen_busy <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                a_q   <= req_a;
                b_q   <= req_b;
                sgn_q <= req_sgn;
                rem_q <= req_rem;
                tag_q <= req_tag;
                dz_q  <= b_zero;
                res_q <= b_zero ? (req_rem ? req_a : '1) : ovf ? (req_rem ? '0 : MIN_NEG) : hit_data;
            end
            if (state == ISSUE) seen_busy <= 1'b0;
            else if (state == WAIT && !div_can_accept_cmd) seen_busy <= 1'b1;
            if (state == WAIT && done) res_q <= rem_q ? div_rem : div_quot;
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed checks of div_issue_ctrl against a behavioural divider with no reset.
module tb_div_issue_ctrl;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_sgn = 1'b0, req_rem = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_dz;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic        div_enable, div_unsgn_or_sgn;
    logic [31:0] div_num, div_denom;
    logic        m_can = 1'b1, m_dr = 1'b0, m_pend = 1'b0, m_s = 1'b0;
    logic [31:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;
    int          m_cnt = 0, m_lat = 0, en_cnt = 0;
    bit          keep_dr = 1'b0, slow = 1'b0;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    div_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sgn(req_sgn), .req_rem(req_rem),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_dz(resp_dz),
        .div_enable(div_enable), .div_unsgn_or_sgn(div_unsgn_or_sgn),
        .div_num(div_num), .div_denom(div_denom),
        .div_can_accept_cmd(m_can), .div_data_ready(m_dr),
        .div_quot(m_q), .div_rem(m_r)
    );
    // divider model: results appear only at completion, data_ready persists until next command
    always @(posedge clk) begin
        if (div_enable) en_cnt <= en_cnt + 1;
        if (m_pend) begin
            m_can  <= 1'b0;
            m_pend <= 1'b0;
        end else if (div_enable && m_can) begin
            if (slow) m_pend <= 1'b1;
            else m_can <= 1'b0;
            if (!keep_dr) m_dr <= 1'b0;
            m_cnt <= m_lat;
            m_a   <= div_num;
            m_b   <= div_denom;
            m_s   <= div_unsgn_or_sgn;
        end else if (!m_can) begin
            if (m_cnt == 0) begin
                m_can <= 1'b1;
                m_dr  <= 1'b1;
                if (m_s) begin
                    m_q <= $signed(m_a) / $signed(m_b);
                    m_r <= $signed(m_a) % $signed(m_b);
                end else begin
                    m_q <= m_a / m_b;
                    m_r <= m_a % m_b;
                end
            end else m_cnt <= m_cnt - 1;
        end
    end
    task automatic issue(input logic s, input logic rm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input int hold, output logic [31:0] d,
                         output logic [3:0] tg, output logic dz, output int cyc, output bit stable);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_sgn = s; req_rem = rm; req_a = a; req_b = b; req_tag = t;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!resp_valid) cyc = -1;
        d = resp_data; tg = resp_tag; dz = resp_dz; stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== d || resp_tag !== tg || resp_dz !== dz || req_ready !== 1'b0)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask
    logic [31:0] d;
    logic [3:0]  tg;
    logic        dz;
    int          cyc, e0;
    bit          st;
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, div_enable, resp_dz} !== 4'b0 || resp_data !== 32'h0 || resp_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b en=%b data=%h exp all zero", req_ready, resp_valid, div_enable, resp_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    endtask
    task automatic test_unsigned();
        e0 = en_cnt;
        issue(1'b0, 1'b0, 32'd100, 32'd7, 4'h3, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'd14 || tg !== 4'h3 || dz !== 1'b0) begin errors++; $display("FAIL udiv got %h/%h/%b exp 0000000e/3/0", d, tg, dz); end
        checks++;
        if (cyc !== 4 || en_cnt - e0 !== 1) begin errors++; $display("FAIL udiv_timing got cyc=%0d en=%0d exp 4/1", cyc, en_cnt - e0); end
        e0 = en_cnt;
        issue(1'b0, 1'b1, 32'd100, 32'd7, 4'h5, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'd2 || tg !== 4'h5) begin errors++; $display("FAIL urem got %h/%h exp 00000002/5", d, tg); end
        checks++;
        if (cyc !== (CACHE ? 1 : 4) || en_cnt - e0 !== (CACHE ? 0 : 1)) begin
            errors++;
            $display("FAIL urem_timing got cyc=%0d en=%0d exp %0d/%0d", cyc, en_cnt - e0, CACHE ? 1 : 4, CACHE ? 0 : 1);
        end
    endtask
    task automatic test_signed();
        issue(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 4'h1, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'hFFFFFFFD) begin errors++; $display("FAIL sdiv got %h exp fffffffd", d); end
        issue(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 4'h2, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL srem got %h exp ffffffff", d); end
        e0 = en_cnt;
        issue(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 4'h4, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'h7FFFFFFC || en_cnt - e0 !== 1) begin errors++; $display("FAIL sgn_change got %h en=%0d exp 7ffffffc en=1", d, en_cnt - e0); end
    endtask
    task automatic test_div_zero();
        e0 = en_cnt;
        issue(1'b0, 1'b1, 32'h1234, 32'd0, 4'h6, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'h1234 || dz !== 1'b1 || tg !== 4'h6) begin errors++; $display("FAIL dz_rem got %h dz=%b tag=%h exp 00001234 dz=1 tag=6", d, dz, tg); end
        checks++;
        if (cyc !== 1 || en_cnt !== e0) begin errors++; $display("FAIL dz_timing got cyc=%0d en=%0d exp 1/0", cyc, en_cnt - e0); end
        issue(1'b1, 1'b0, 32'h1234, 32'd0, 4'h7, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'hFFFFFFFF || dz !== 1'b1 || en_cnt !== e0) begin errors++; $display("FAIL dz_quot got %h dz=%b en=%0d exp ffffffff dz=1 en=0", d, dz, en_cnt - e0); end
    endtask
    task automatic test_overflow();
        e0 = en_cnt;
        issue(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 4'h8, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'h80000000 || dz !== 1'b0 || cyc !== 1) begin errors++; $display("FAIL ovf_quot got %h dz=%b cyc=%0d exp 80000000 dz=0 cyc=1", d, dz, cyc); end
        issue(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 4'h9, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'h0 || en_cnt !== e0) begin errors++; $display("FAIL ovf_rem got %h en=%0d exp 00000000 en=0", d, en_cnt - e0); end
        issue(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 4'hA, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'h0 || cyc !== 4 || en_cnt - e0 !== 1) begin errors++; $display("FAIL unsigned_minneg got %h cyc=%0d en=%0d exp 00000000 cyc=4 en=1", d, cyc, en_cnt - e0); end
    endtask
    task automatic test_latency();
        m_lat = 2;
        issue(1'b0, 1'b0, 32'd1000, 32'd10, 4'hB, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'd100 || cyc !== 6) begin errors++; $display("FAIL latency got %h cyc=%0d exp 00000064 cyc=6", d, cyc); end
    endtask
    task automatic test_stale();
        m_lat = 1; slow = 1'b1; keep_dr = 1'b1;
        issue(1'b0, 1'b0, 32'd77, 32'd5, 4'hC, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'd15 || cyc !== 6) begin errors++; $display("FAIL stale_ready got %h cyc=%0d exp 0000000f cyc=6", d, cyc); end
        m_lat = 0; slow = 1'b0; keep_dr = 1'b0;
    endtask
    task automatic test_hold();
        issue(1'b0, 1'b1, 32'd9, 32'd4, 4'hD, 5, d, tg, dz, cyc, st);
        checks++;
        if (st !== 1'b1 || d !== 32'd1 || tg !== 4'hD) begin errors++; $display("FAIL hold got stable=%b data=%h tag=%h exp 1/00000001/d", st, d, tg); end
    endtask
    task automatic test_reset_wait();
        m_lat = 20;
        @(negedge clk);
        req_valid = 1'b1; req_sgn = 1'b0; req_rem = 1'b0; req_a = 32'd60; req_b = 32'd7; req_tag = 4'hE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, div_enable, req_ready} !== 3'b0 || div_num !== 32'h0 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_wait got vld=%b en=%b rdy=%b num=%h data=%h exp all zero", resp_valid, div_enable, req_ready, div_num, resp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_lat = 0;
        e0 = en_cnt;
        issue(1'b0, 1'b0, 32'd50, 32'd3, 4'hF, 0, d, tg, dz, cyc, st);
        checks++;
        if (d !== 32'd16 || tg !== 4'hF || en_cnt - e0 !== 1) begin errors++; $display("FAIL after_reset got %h tag=%h en=%0d exp 00000010 tag=f en=1", d, tg, en_cnt - e0); end
        checks++;
        if (cyc <= 6) begin errors++; $display("FAIL after_reset_wait got cyc=%0d exp >6", cyc); end
    endtask
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_latency();
        test_stale();
        test_hold();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
